regfile_write_sched: RTL and testbench

- Scheduler for the 32x32 register file's single write port (regWrite / escrita / dataWrite).
- Shares the port between two writeback requesters: ALU result (port A) and load-return (port B).
- Runs a clear sweep that zeroes all registers after reset or on command.
- Sits between the execute/memory stages and the register file. All write-port outputs are registered.

---
 rtl/regfile_sched_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/regfile_write_sched.sv | 123 ++++++++++++
 tb/tb_regfile_write_sched.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sched_pkg.sv
// Shared types and default sizing for the register-file write-port scheduler.
package regfile_sched_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NREGS_DEF  = 32;

    typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} sched_state_e;
    typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with combinational one-hot grant.
// On contention the requester not granted last wins; history moves only on a grant.
module rr_arbiter2
    import regfile_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_i,
    input  logic [1:0] req_i,   // [0] = A, [1] = B
    output logic [1:0] gnt_o
);

    req_id_e rr_last_q, rr_last_d;

    always_comb begin
        gnt_o     = 2'b00;
        rr_last_d = rr_last_q;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = (rr_last_q == REQ_A) ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
            if (gnt_o[0]) begin
                rr_last_d = REQ_A;
            end else if (gnt_o[1]) begin
                rr_last_d = REQ_B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last_q <= REQ_A;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler for the register file: zeroing sweep, then A/B writeback arbitration.
// Optional REGSCHED_STATS_EN adds a saturating conflict_cnt of contended RUN cycles.
module regfile_write_sched
    import regfile_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    input  logic              clear_start,
    output logic              busy,
`ifdef REGSCHED_STATS_EN
    output logic [15:0]       conflict_cnt,
`endif
    output logic              regWrite,
    output logic [ADDR_W-1:0] escrita,
    output logic [DATA_W-1:0] dataWrite
);

    // Pointer reaches NREGS: that last CLEAR cycle lets the final zero write
    // drain while busy is still high, so no request is granted mid-sweep.
    localparam int PTR_W = $clog2(NREGS + 1);

    sched_state_e      state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        gnt;
    logic              arb_en;

    assign arb_en = (state_q == RUN) && !clear_start;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (arb_en),
        .req_i ({b_valid, a_valid}),
        .gnt_o (gnt)
    );

    assign a_ready   = gnt[0];
    assign b_ready   = gnt[1];
    assign busy      = (state_q == CLEAR);
    assign regWrite  = we_q;
    assign escrita   = waddr_q;
    assign dataWrite = wdata_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (state_q == CLEAR) begin
            if (ptr_q < PTR_W'(NREGS)) begin
                we_d    = 1'b1;
                waddr_d = ADDR_W'(ptr_q);
                wdata_d = '0;
                ptr_d   = ptr_q + PTR_W'(1);
            end else begin
                state_d = RUN;
            end
        end else if (clear_start) begin
            state_d = CLEAR;
            ptr_d   = '0;
        end else if (gnt[0]) begin
            // $zero is accepted but never written
            if (a_addr != '0) begin
                we_d    = 1'b1;
                waddr_d = a_addr;
                wdata_d = a_data;
            end
        end else if (gnt[1]) begin
            if (b_addr != '0) begin
                we_d    = 1'b1;
                waddr_d = b_addr;
                wdata_d = b_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef REGSCHED_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if ((state_q == RUN) && a_valid && b_valid && (conflict_q != 16'hFFFF)) begin
            conflict_q <= conflict_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule

// File: tb/tb_regfile_write_sched.sv
// Bench for regfile_write_sched: directed vector table, sweep/reset sequences, random run vs. model.
module tb_regfile_write_sched;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          a_valid = 1'b0, b_valid = 1'b0, clear_start = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_ready, b_ready, busy, regWrite;
    logic [AW-1:0] escrita;
    logic [DW-1:0] dataWrite;
`ifdef REGSCHED_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_write_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .clear_start (clear_start),
        .busy        (busy),
`ifdef REGSCHED_STATS_EN
        .conflict_cnt(conflict_cnt),
`endif
        .regWrite    (regWrite),
        .escrita     (escrita),
        .dataWrite   (dataWrite)
    );

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic          bv;
        logic [AW-1:0] ba;
        logic [DW-1:0] bd;
        logic          cs;
        logic          ear;
        logic          ebr;
        logic          ewe;
        logic          cw;   // compare escrita/dataWrite
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
    } vec_t;

    vec_t vt [0:9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // All sequence tasks are entered and left at a negedge.
    task automatic apply_vec(input vec_t v, input int idx);
        a_valid = v.av; a_addr = v.aa; a_data = v.ad;
        b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
        clear_start = v.cs;
        #1;
        chk($sformatf("v%0d a_ready", idx), a_ready, v.ear);
        chk($sformatf("v%0d b_ready", idx), b_ready, v.ebr);
        @(posedge clk); #1;
        clear_start = 1'b0;
        chk($sformatf("v%0d regWrite", idx), regWrite, v.ewe);
        if (v.cw) begin
            chk($sformatf("v%0d escrita", idx), escrita, v.eaddr);
            chk($sformatf("v%0d dataWrite", idx), dataWrite, v.edata);
        end
        @(negedge clk);
    endtask

    // Called in the first busy cycle; ends in the first RUN cycle.
    task automatic sweep_check(input int cs_at);
        for (int k = 0; k <= NR; k++) begin
            if (k == cs_at) clear_start = 1'b1;
            #1;
            chk($sformatf("sweep%0d busy", k), busy, 1'b1);
            chk($sformatf("sweep%0d a_ready", k), a_ready, 1'b0);
            chk($sformatf("sweep%0d b_ready", k), b_ready, 1'b0);
            @(posedge clk); #1;
            clear_start = 1'b0;
            if (k < NR) begin
                chk($sformatf("sweep%0d regWrite", k), regWrite, 1'b1);
                chk($sformatf("sweep%0d escrita", k), escrita, 64'(k));
                chk($sformatf("sweep%0d dataWrite", k), dataWrite, 64'd0);
            end else begin
                chk("sweep_end regWrite", regWrite, 1'b0);
            end
            @(negedge clk);
        end
        #1;
        chk("sweep_done busy", busy, 1'b0);
    endtask

    // Reference model state
    bit m_sw;
    int m_s, m_last, m_conf;

    initial begin
        logic pav, pbv, cs;
        logic [AW-1:0] paa, pba;
        logic [DW-1:0] pad, pbd;
        int g;
        logic ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;

        vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
        vt[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF};
        vt[2] = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd9,  32'h99999999, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9,  32'h99999999};
        vt[3] = '{1'b1, 5'd1,  32'h11111111, 1'b1, 5'd10, 32'hAAAAAAAA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd1,  32'h11111111};
        vt[4] = '{1'b1, 5'd2,  32'h22222222, 1'b1, 5'd10, 32'hAAAAAAAA, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'hAAAAAAAA};
        vt[5] = '{1'b1, 5'd2,  32'h22222222, 1'b1, 5'd11, 32'hBBBBBBBB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd2,  32'h22222222};
        vt[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h00001234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        vt[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'hCAFEF00D};
        vt[8] = '{1'b1, 5'd7,  32'h00000007, 1'b1, 5'd3,  32'h00000003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3,  32'h00000003};
        vt[9] = '{1'b1, 5'd7,  32'h00000007, 1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0};

        // Reset values, with a request pending to show ready stays low
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h5;
        #12;
        chk("rst regWrite", regWrite, 1'b0);
        chk("rst escrita", escrita, 64'd0);
        chk("rst dataWrite", dataWrite, 64'd0);
        chk("rst a_ready", a_ready, 1'b0);
        chk("rst b_ready", b_ready, 1'b0);
        chk("rst busy", busy, 1'b1);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b1;
        sweep_check(-1);

        for (int i = 0; i < 10; i++) apply_vec(vt[i], i);

        // clear_start blocked A; A keeps requesting through the sweep
        sweep_check(-1);
        chk("post_clear a_ready", a_ready, 1'b1);
        @(posedge clk); #1;
        chk("post_clear regWrite", regWrite, 1'b1);
        chk("post_clear escrita", escrita, 64'd7);
        @(negedge clk);
        a_valid = 1'b0;

        // clear_start during a sweep must not restart it
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        @(negedge clk);
        sweep_check(5);

        // Reset with ptr == 17
        clear_start = 1'b1;
        @(posedge clk); #1;
        clear_start = 1'b0;
        @(negedge clk);
        repeat (17) @(negedge clk);
        chk("pre_rst escrita", escrita, 64'd16);
        rst_n = 1'b0;
        #1;
        chk("midrst regWrite", regWrite, 1'b0);
        chk("midrst escrita", escrita, 64'd0);
        chk("midrst busy", busy, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check(-1);

        // Randomized run against the reference model, from a fresh reset
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_sw = 1'b1; m_s = 0; m_last = 0; m_conf = 0;
        pav = 1'b0; pbv = 1'b0;
        paa = '0; pba = '0; pad = '0; pbd = '0;
        for (int c = 0; c < 1500; c++) begin
            if (!pav) begin
                pav = ($urandom_range(9) < 6);
                paa = ($urandom_range(7) == 0) ? '0 : AW'($urandom_range(NR - 1));
                pad = $urandom;
            end
            if (!pbv) begin
                pbv = ($urandom_range(9) < 5);
                pba = ($urandom_range(7) == 0) ? '0 : AW'($urandom_range(NR - 1));
                pbd = $urandom;
            end
            cs = ($urandom_range(99) == 0);
            a_valid = pav; a_addr = paa; a_data = pad;
            b_valid = pbv; b_addr = pba; b_data = pbd;
            clear_start = cs;

            g = -1; ewe = 1'b0; eaddr = '0; edata = '0;
            if (m_sw) begin
                if (m_s < NR) begin
                    ewe = 1'b1; eaddr = AW'(m_s);
                end
                m_s++;
                if (m_s > NR) m_sw = 1'b0;
                #1;
                chk("rnd busy", busy, 1'b1);
            end else begin
                if (pav && pbv && m_conf < 16'hFFFF) m_conf++;
                if (cs) begin
                    m_sw = 1'b1; m_s = 0;
                end else begin
                    if (pav && pbv) g = 1 - m_last;
                    else if (pav) g = 0;
                    else if (pbv) g = 1;
                    if (g >= 0) m_last = g;
                    if (g == 0 && paa != '0) begin ewe = 1'b1; eaddr = paa; edata = pad; end
                    if (g == 1 && pba != '0) begin ewe = 1'b1; eaddr = pba; edata = pbd; end
                end
                #1;
                chk("rnd busy", busy, 1'b0);
            end
            chk("rnd a_ready", a_ready, (g == 0));
            chk("rnd b_ready", b_ready, (g == 1));
            @(posedge clk); #1;
            chk("rnd regWrite", regWrite, ewe);
            if (ewe) begin
                chk("rnd escrita", escrita, eaddr);
                chk("rnd dataWrite", dataWrite, edata);
            end
            if (g == 0) pav = 1'b0;
            if (g == 1) pbv = 1'b0;
            @(negedge clk);
        end
`ifdef REGSCHED_STATS_EN
        chk("conflict_cnt", conflict_cnt, 64'(m_conf));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
